full_add: RTL and testbench

//   Parameterizable binary adder: sum = a + b + c1, carry-out c2. Combinational
//   sum/carry outputs serve glue logic; registered copies with a valid flag serve

---
 rtl/full_add_pkg.sv | 6 +
 rtl/full_add_bit.sv | 13 +
 rtl/full_add.sv | 51 +++++
 tb/tb_full_add.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/full_add_pkg.sv
// Shared constants for the full_add ripple-carry adder.
package full_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;

endpackage : full_add_pkg

// File: rtl/full_add_bit.sv
// One-bit full adder cell; the top chains WIDTH of these into a ripple adder.
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_add_bit

// File: rtl/full_add.sv
// Unsigned WIDTH-bit adder: zero-latency sum/carry plus a one-cycle registered copy with valid.
module full_add
  import full_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c1,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             c2,
  output logic [WIDTH-1:0] s_q,
  output logic             c2_q,
  output logic             out_valid
);

  // carry[i] feeds bit i; carry[WIDTH] is the adder carry-out
  logic [WIDTH:0] carry;

  assign carry[0] = c1;
  assign c2       = carry[WIDTH];

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    full_add_bit u_bit (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (s[i]),
      .co (carry[i+1])
    );
  end

  // Result register: reset wins over in_valid; an idle cycle holds the last result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q       <= '0;
      c2_q      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q  <= s;
        c2_q <= c2;
      end
    end
  end

endmodule : full_add

// File: tb/tb_full_add.sv
// Self-checking bench for full_add at WIDTH=1, 8 and 16.
module tb_full_add;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a1, b1, c11, iv1, s1, c21, sq1, c2q1, ov1;
  logic [7:0]  a8, b8, s8, sq8;
  logic        c18, iv8, c28, c2q8, ov8;
  logic [15:0] a16, b16, s16, sq16;
  logic        c116, iv16, c216, c2q16, ov16;

  full_add #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c1(c11), .in_valid(iv1),
    .s(s1), .c2(c21), .s_q(sq1), .c2_q(c2q1), .out_valid(ov1));

  full_add #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c1(c18), .in_valid(iv8),
    .s(s8), .c2(c28), .s_q(sq8), .c2_q(c2q8), .out_valid(ov8));

  full_add #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c1(c116), .in_valid(iv16),
    .s(s16), .c2(c216), .s_q(sq16), .c2_q(c2q16), .out_valid(ov16));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic a, b, c1, s, c2;
  } vec1_t;

  typedef struct {
    logic [7:0] a, b;
    logic       c1;
    logic [7:0] s;
    logic       c2;
  } vec8_t;

  typedef struct {
    logic        ov;
    logic [15:0] s;
    logic        c;
  } exp16_t;

  vec1_t  tbl1[5];
  vec8_t  tbl8[2];
  exp16_t sb[$];

  initial begin
    logic [16:0] res;
    logic [15:0] hold_s;
    logic        hold_c;
    exp16_t      e;
    logic        ea, eb, ec;

    tbl1[0] = '{a:1'b0, b:1'b0, c1:1'b0, s:1'b0, c2:1'b0};
    tbl1[1] = '{a:1'b0, b:1'b0, c1:1'b1, s:1'b1, c2:1'b0};
    tbl1[2] = '{a:1'b0, b:1'b1, c1:1'b0, s:1'b1, c2:1'b0};
    tbl1[3] = '{a:1'b1, b:1'b0, c1:1'b1, s:1'b0, c2:1'b1};
    tbl1[4] = '{a:1'b1, b:1'b1, c1:1'b1, s:1'b1, c2:1'b1};
    tbl8[0] = '{a:8'hFF, b:8'h00, c1:1'b1, s:8'h00, c2:1'b1};
    tbl8[1] = '{a:8'h7F, b:8'h01, c1:1'b0, s:8'h80, c2:1'b0};

    rst_n = 1'b0;
    {a1, b1, c11, iv1} = '0;
    {a8, b8, c18, iv8} = '0;
    {a16, b16, c116, iv16} = '0;
    repeat (3) @(negedge clk);

    check("rst_s_q8", 32'(sq8), 32'h0);
    check("rst_c2_q8", 32'(c2q8), 32'h0);
    check("rst_ov8", 32'(ov8), 32'h0);
    check("rst_ov16", 32'(ov16), 32'h0);
    rst_n = 1'b1;

    // WIDTH=1 directed vectors, 5 ns apart
    for (int i = 0; i < 5; i++) begin
      a1 = tbl1[i].a; b1 = tbl1[i].b; c11 = tbl1[i].c1;
      #1;
      check($sformatf("w1_s[%0d]", i), 32'(s1), 32'(tbl1[i].s));
      check($sformatf("w1_c2[%0d]", i), 32'(c21), 32'(tbl1[i].c2));
      #4;
    end

    // WIDTH=1 exhaustive against truth equations
    for (int i = 0; i < 8; i++) begin
      ea = i[2]; eb = i[1]; ec = i[0];
      a1 = ea; b1 = eb; c11 = ec;
      #1;
      check($sformatf("w1x_s[%0d]", i), 32'(s1), 32'(ea ^ eb ^ ec));
      check($sformatf("w1x_c2[%0d]", i), 32'(c21), 32'((ea & eb) | (ea & ec) | (eb & ec)));
      #4;
    end

    // WIDTH=8 wrap boundaries
    for (int i = 0; i < 2; i++) begin
      a8 = tbl8[i].a; b8 = tbl8[i].b; c18 = tbl8[i].c1;
      #1;
      check($sformatf("w8_s[%0d]", i), 32'(s8), 32'(tbl8[i].s));
      check($sformatf("w8_c2[%0d]", i), 32'(c28), 32'(tbl8[i].c2));
      #4;
    end

    // Registered capture then hold
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; c18 = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    check("reg_s_q", 32'(sq8), 32'h47);
    check("reg_c2_q", 32'(c2q8), 32'h0);
    check("reg_ov", 32'(ov8), 32'h1);
    iv8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; c18 = 1'b1;
    @(negedge clk);
    check("hold_ov", 32'(ov8), 32'h0);
    check("hold_s_q", 32'(sq8), 32'h47);
    check("hold_c2_q", 32'(c2q8), 32'h0);

    // Reset beats in_valid; comb path still live during reset
    rst_n = 1'b0; iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; c18 = 1'b0;
    #1;
    check("rstc_s", 32'(s8), 32'h00);
    check("rstc_c2", 32'(c28), 32'h1);
    @(negedge clk);
    check("rstv_s_q", 32'(sq8), 32'h0);
    check("rstv_c2_q", 32'(c2q8), 32'h0);
    check("rstv_ov", 32'(ov8), 32'h0);
    rst_n = 1'b1; a8 = 8'h01; b8 = 8'h02; c18 = 1'b0;
    @(negedge clk);
    check("post_rst_ov", 32'(ov8), 32'h1);
    check("post_rst_s_q", 32'(sq8), 32'h03);
    iv8 = 1'b0;

    // WIDTH=16 random stream with scoreboard
    hold_s = sq16;
    hold_c = c2q16;
    hold_s = 16'h0;
    hold_c = 1'b0;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("rnd_q[%0d]", i), {14'h0, ov16, sq16, c2q16}, {14'h0, e.ov, e.s, e.c});
      end
      if (i == 1000) break;
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      c116 = 1'($urandom);
      iv16 = ($urandom_range(0, 3) != 0);
      res  = {1'b0, a16} + {1'b0, b16} + 17'(c116);
      #1;
      check($sformatf("rnd_c[%0d]", i), {15'h0, c216, s16}, {15'h0, res});
      if (iv16) begin
        hold_s = res[15:0];
        hold_c = res[16];
      end
      sb.push_back('{ov: iv16, s: hold_s, c: hold_c});
    end
    check("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_full_add
